// File: rtl/timestamp_stream_decoder_pkg.sv
// timestamp_stream_decoder_pkg: word layout, type codes and FSM encoding shared by producer and decoder
package timestamp_stream_decoder_pkg;
  localparam int WORD_W   = 32;
  localparam int ID_MSB   = 31;
  localparam int ID_LSB   = 28;
  localparam int TYPE_MSB = 27;
  localparam int TYPE_LSB = 24;
  localparam logic [3:0] TYPE_TS_LO  = 4'd1;
  localparam logic [3:0] TYPE_TS_MID = 4'd2;
  localparam logic [3:0] TYPE_TS_HI  = 4'd3;
  typedef enum logic [1:0] {W1, W2, W3} state_t;
  function automatic logic [3:0] word_id(input logic [WORD_W-1:0] w);
    return w[ID_MSB:ID_LSB];
  endfunction
  function automatic logic [3:0] word_type(input logic [WORD_W-1:0] w);
    return w[TYPE_MSB:TYPE_LSB];
  endfunction
endpackage

// File: rtl/timestamp_stream_decoder_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  // count up on inc until every bit is set
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/timestamp_stream_decoder.sv
// timestamp_stream_decoder: reassembles 64-bit timestamps from three typed 32-bit FIFO words
module timestamp_stream_decoder
  import timestamp_stream_decoder_pkg::*;
#(
  parameter logic [3:0] IDENTIFIER = 4'b0001
) (
  input  logic        BUS_CLK,
  input  logic        BUS_RST,
  input  logic        ENABLE,
  input  logic        FIFO_EMPTY,
  input  logic [31:0] FIFO_DATA,
  output logic        FIFO_READ,
  output logic        TS_VALID,
  input  logic        TS_READY,
  output logic [63:0] TIMESTAMP,
  output logic [7:0]  SEQ_ERR_CNT,
  output logic [7:0]  ORDER_ERR_CNT,
  output logic [15:0] FOREIGN_CNT
);
  state_t      state;
  logic [23:0] lo, mid;
  logic        have_prev;
  logic        stall, mine, foreign, is_lo, adv_mid, complete, seq_err, order_err;
  logic [3:0]  typ;
  logic [63:0] next_ts;
  assign stall     = state == W3 && TS_VALID && !TS_READY;
  assign FIFO_READ = ENABLE && !FIFO_EMPTY && !stall && !BUS_RST;
  assign typ       = word_type(FIFO_DATA);
  assign mine      = FIFO_READ && word_id(FIFO_DATA) == IDENTIFIER;
  assign foreign   = FIFO_READ && word_id(FIFO_DATA) != IDENTIFIER;
  assign is_lo     = mine && typ == TYPE_TS_LO;
  assign adv_mid   = mine && state == W2 && typ == TYPE_TS_MID;
  assign complete  = mine && state == W3 && typ == TYPE_TS_HI && FIFO_DATA[23:16] == 8'd0;
  assign seq_err   = mine && !(is_lo && state == W1) && !adv_mid && !complete;
  assign next_ts   = {FIFO_DATA[15:0], mid, lo};
  assign order_err = complete && have_prev && next_ts <= TIMESTAMP;
  // frame FSM with registered timestamp output; a stray type-1 word restarts the frame
  always_ff @(posedge BUS_CLK)
    if (BUS_RST) begin
      state     <= W1;
      lo        <= '0;
      mid       <= '0;
      have_prev <= 1'b0;
      TS_VALID  <= 1'b0;
      TIMESTAMP <= '0;
    end else begin
      if (TS_VALID && TS_READY) TS_VALID <= 1'b0;
      if (mine) state <= complete ? W1 : adv_mid ? W3 : is_lo ? W2 : W1;
      if (is_lo) lo <= FIFO_DATA[23:0];
      if (adv_mid) mid <= FIFO_DATA[23:0];
      if (complete) begin
        TIMESTAMP <= next_ts;
        TS_VALID  <= 1'b1;
        have_prev <= 1'b1;
      end
    end
  sat_counter #(.WIDTH(8))  u_seq     (.clk(BUS_CLK), .rst(BUS_RST), .inc(seq_err),   .count(SEQ_ERR_CNT));
  sat_counter #(.WIDTH(8))  u_order   (.clk(BUS_CLK), .rst(BUS_RST), .inc(order_err), .count(ORDER_ERR_CNT));
  sat_counter #(.WIDTH(16)) u_foreign (.clk(BUS_CLK), .rst(BUS_RST), .inc(foreign),   .count(FOREIGN_CNT));
endmodule

// File: tb/tb_timestamp_stream_decoder.sv
// tb_timestamp_stream_decoder: FWFT FIFO model feeding the decoder, scoreboard on accepted timestamps
module tb_timestamp_stream_decoder;
  logic        clk = 1'b0;
  logic        rst, en, fifo_empty, fifo_read, ts_valid, ts_ready;
  logic [31:0] fifo_data;
  logic [63:0] timestamp;
  logic [7:0]  seq_cnt, order_cnt;
  logic [15:0] foreign_cnt;
  int checks = 0, errors = 0;
  int cyc = 0, last_pop = -1, first_valid = -1, nvalid = 0, acc = 0;
  logic [31:0] fifo_q[$];
  logic [63:0] exp_q[$];
  typedef struct {
    logic [31:0] w1, w2, w3;
    logic        emit;
    logic [63:0] ts;
  } vec_t;
  vec_t tbl[5];

  always #5 clk = ~clk;

  timestamp_stream_decoder #(.IDENTIFIER(4'b0001)) dut (
    .BUS_CLK(clk), .BUS_RST(rst), .ENABLE(en), .FIFO_EMPTY(fifo_empty),
    .FIFO_DATA(fifo_data), .FIFO_READ(fifo_read), .TS_VALID(ts_valid),
    .TS_READY(ts_ready), .TIMESTAMP(timestamp), .SEQ_ERR_CNT(seq_cnt),
    .ORDER_ERR_CNT(order_cnt), .FOREIGN_CNT(foreign_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    logic rd;
    fifo_empty = fifo_q.size() == 0;
    fifo_data  = fifo_empty ? 32'd0 : fifo_q[0];
    @(negedge clk);
    if (ts_valid) begin
      nvalid++;
      if (first_valid < 0) first_valid = cyc;
    end
    if (ts_valid && ts_ready) begin
      acc++;
      if (exp_q.size() == 0) chk("unexpected_ts", timestamp, 64'hx);
      else chk("ts", timestamp, exp_q.pop_front());
    end
    rd = fifo_read;
    if (rd) last_pop = cyc;
    @(posedge clk);
    #1;
    if (rd) void'(fifo_q.pop_front());
    fifo_empty = fifo_q.size() == 0;
    fifo_data  = fifo_empty ? 32'd0 : fifo_q[0];
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain();
    int k = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && k < 1000) begin
      step();
      k++;
    end
    if (k >= 1000) chk("drain_timeout", 64'(fifo_q.size() + exp_q.size()), 64'd0);
    run(3);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic frame(input logic [31:0] a, b, c);
    fifo_q.push_back(a);
    fifo_q.push_back(b);
    fifo_q.push_back(c);
  endtask

  initial begin
    tbl[0] = '{32'h11000010, 32'h12000020, 32'h13000004, 1'b1, 64'h0004_000020_000010};
    tbl[1] = '{32'h11FFFFFF, 32'h12FFFFFF, 32'h13000005, 1'b1, 64'h0005_FFFFFF_FFFFFF};
    tbl[2] = '{32'h11000001, 32'h12000001, 32'h13010006, 1'b0, 64'h0};
    tbl[3] = '{32'h11000000, 32'h12000000, 32'h13000006, 1'b1, 64'h0006_000000_000000};
    tbl[4] = '{32'h11123456, 32'h12ABCDEF, 32'h1300FFFF, 1'b1, 64'hFFFF_ABCDEF_123456};
    rst = 1'b1; en = 1'b1; ts_ready = 1'b1;
    fifo_q.push_back(32'h11000001);
    run(2);
    chk("read_in_reset", 64'(fifo_read), 64'd0);
    chk("rst_valid", 64'(ts_valid), 64'd0);
    chk("rst_ts", timestamp, 64'd0);
    chk("rst_seq", 64'(seq_cnt), 64'd0);
    chk("rst_order", 64'(order_cnt), 64'd0);
    chk("rst_foreign", 64'(foreign_cnt), 64'd0);
    chk("fifo_kept_in_reset", 64'(fifo_q.size()), 64'd1);
    rst = 1'b0;
    // basic frame and its latency
    fifo_q.push_back(32'h12000002);
    fifo_q.push_back(32'h13000003);
    exp_q.push_back(64'h0003_000002_000001);
    nvalid = 0; first_valid = -1;
    drain();
    chk("basic_latency", 64'(first_valid), 64'(last_pop + 1));
    chk("basic_pulses", 64'(nvalid), 64'd1);
    // table of frames, including a type-3 word with a nonzero reserved byte
    for (int i = 0; i < 5; i++) begin
      frame(tbl[i].w1, tbl[i].w2, tbl[i].w3);
      if (tbl[i].emit) exp_q.push_back(tbl[i].ts);
    end
    drain();
    chk("tbl_seq", 64'(seq_cnt), 64'd1);
    chk("tbl_order", 64'(order_cnt), 64'd0);
    // missing type-2 word, then a good frame
    do_reset();
    fifo_q.push_back(32'h11000005);
    fifo_q.push_back(32'h13000007);
    run(4);
    chk("seqerr_cnt", 64'(seq_cnt), 64'd1);
    chk("seqerr_no_valid", 64'(ts_valid), 64'd0);
    frame(32'h11000001, 32'h12000002, 32'h13000003);
    exp_q.push_back(64'h0003_000002_000001);
    drain();
    // foreign word mid-frame
    do_reset();
    fifo_q.push_back(32'h11000001);
    fifo_q.push_back(32'h21000009);
    fifo_q.push_back(32'h12000002);
    fifo_q.push_back(32'h13000003);
    exp_q.push_back(64'h0003_000002_000001);
    drain();
    chk("foreign_cnt", 64'(foreign_cnt), 64'd1);
    chk("foreign_seq", 64'(seq_cnt), 64'd0);
    // backpressure holds the first result and blocks the second type-3 pop
    do_reset();
    ts_ready = 1'b0;
    frame(32'h11000001, 32'h12000000, 32'h13000001);
    frame(32'h11000002, 32'h12000000, 32'h13000002);
    run(15);
    chk("bp_valid", 64'(ts_valid), 64'd1);
    chk("bp_ts_held", timestamp, 64'h0001_000000_000001);
    chk("bp_no_read", 64'(fifo_read), 64'd0);
    chk("bp_fifo_left", 64'(fifo_q.size()), 64'd1);
    exp_q.push_back(64'h0001_000000_000001);
    exp_q.push_back(64'h0002_000000_000002);
    ts_ready = 1'b1;
    acc = 0;
    run(2);
    chk("bp_back_to_back", 64'(acc), 64'd2);
    drain();
    // equal timestamps count as out of order, then counter saturation
    do_reset();
    frame(32'h1100000A, 32'h12000000, 32'h13000000);
    frame(32'h1100000A, 32'h12000000, 32'h13000000);
    exp_q.push_back(64'd10);
    exp_q.push_back(64'd10);
    drain();
    chk("order_cnt", 64'(order_cnt), 64'd1);
    for (int i = 0; i < 300; i++) fifo_q.push_back(32'h13000000);
    drain();
    chk("seq_saturate", 64'(seq_cnt), 64'd255);
    chk("order_kept", 64'(order_cnt), 64'd1);
    // reset mid-frame discards the partial timestamp
    do_reset();
    fifo_q.push_back(32'h11000001);
    fifo_q.push_back(32'h12000002);
    drain();
    do_reset();
    nvalid = 0;
    fifo_q.push_back(32'h13000003);
    drain();
    chk("midrst_seq", 64'(seq_cnt), 64'd1);
    chk("midrst_no_valid", 64'(nvalid), 64'd0);
    // ENABLE low blocks pops only
    do_reset();
    en = 1'b0;
    frame(32'h11000001, 32'h12000002, 32'h13000003);
    run(5);
    chk("en_no_read", 64'(fifo_read), 64'd0);
    chk("en_fifo_kept", 64'(fifo_q.size()), 64'd3);
    en = 1'b1;
    run(1);
    en = 1'b0;
    run(4);
    chk("en_partial_pop", 64'(fifo_q.size()), 64'd2);
    en = 1'b1;
    exp_q.push_back(64'h0003_000002_000001);
    drain();
    chk("en_seq", 64'(seq_cnt), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
